// File: rtl/prog_loader.sv
//=== prog_loader : framed byte-stream imem loader; holds the core in reset until the image verifies
//=== Revision: 1.0
`default_nettype none

module prog_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam int          TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  logic [2:0]        state_q, state_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              in_ready_q, in_ready_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic              imem_we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W:0]   words_q;
  logic [7:0]        len_lo_q;
  logic [15:0]       len_q;
  logic [1:0]        byte_cnt_q;
  logic [23:0]       buf_q;
  logic [7:0]        xor_q;
  logic [TMO_W-1:0]  tmo_q;

  logic              accept, loading, begin_load, word_done, last_word, tmo_hit;
  logic [15:0]       len_full;

  assign accept     = in_valid && in_ready_q;
  assign loading    = state_q inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
  assign begin_load = start && !loading;
  assign len_full   = {in_data, len_lo_q};
  assign word_done  = accept && (state_q == S_DATA) && (byte_cnt_q == 2'd3);
  // Compared one bit wider than the address so a full 2**ADDR_W image ends on the right word
  assign last_word  = ({1'b0, len_q} == (17'(words_q) + 17'd1));
  assign tmo_hit    = loading && !accept && (tmo_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      err_code_q  <= 2'b00;
      in_ready_q  <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_code_q  <= err_code_d;
      in_ready_q  <= in_ready_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_LEN0;
          err_code_d = 2'b00;
        end
      end
      S_LEN0: if (accept) state_d = S_LEN1;
      S_LEN1: begin
        if (accept) begin
          if (len_full == 16'd0) begin
            state_d = S_CSUM;
          end else if ({1'b0, len_full} > MAX_WORDS) begin
            state_d    = S_ERROR;
            err_code_d = 2'b01;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: if (word_done && last_word) state_d = S_CSUM;
      S_CSUM: begin
        if (accept) begin
          if (in_data == xor_q) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ERROR;
            err_code_d = 2'b10;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) begin
      state_d    = S_ERROR;
      err_code_d = 2'b11;
    end
  end

  // Status outputs are registered from the next state so they change on the transition edge
  always_comb begin
    in_ready_d  = state_d inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
    cpu_rst_n_d = (state_d == S_DONE);
    load_done_d = (state_d == S_DONE);
    load_err_d  = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we_q  <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      words_q    <= '0;
      len_lo_q   <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      xor_q      <= '0;
      tmo_q      <= '0;
    end else begin
      imem_we_q <= 1'b0;
      if (begin_load || accept) begin
        tmo_q <= '0;
      end else if (loading) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
      if (begin_load) begin
        byte_cnt_q <= '0;
        xor_q      <= '0;
        words_q    <= '0;
      end
      if (accept) begin
        case (state_q)
          S_LEN0: len_lo_q <= in_data;
          S_LEN1: len_q    <= len_full;
          S_DATA: begin
            xor_q      <= xor_q ^ in_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0:    buf_q[7:0]   <= in_data;
              2'd1:    buf_q[15:8]  <= in_data;
              2'd2:    buf_q[23:16] <= in_data;
              default: begin
                wdata_q   <= {in_data, buf_q};
                waddr_q   <= words_q[ADDR_W-1:0];
                imem_we_q <= 1'b1;
                words_q   <= words_q + 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign err_code     = err_code_q;
  assign words_loaded = words_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
//=== tb_prog_loader : randomized frames against a frame-level model of prog_loader
//=== Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_prog_loader;

  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 40;
  localparam int MAXW    = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              load_done;
  logic              load_err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .load_done(load_done), .load_err(load_err), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int                n_checks = 0;
  int                n_errors = 0;
  int                inject_idx = -1;
  int                rst_viol = 0;
  logic [7:0]        frame_q[$];
  logic [ADDR_W+31:0] wr_q[$];

  always @(negedge clk) begin
    if (imem_we) wr_q.push_back({imem_waddr, imem_wdata});
    if (in_ready && cpu_rst_n) rst_viol++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic build_frame(input int n, input bit good);
    logic [7:0] x;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'(n));
    frame_q.push_back(8'(n >> 8));
    if (n <= MAXW) begin
      x = 8'h00;
      for (int k = 0; k < 4 * n; k++) begin
        b = 8'($urandom);
        x ^= b;
        frame_q.push_back(b);
      end
      frame_q.push_back(good ? x : (x ^ 8'(1 + $urandom_range(0, 254))));
    end
  endtask

  task automatic begin_load();
    wr_q.delete();
    rst_viol = 0;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;      // a byte alongside start must be ignored
    in_data  = 8'hA5;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send_bytes(input int count);
    int gap;
    int waited;
    bit acc;
    for (int i = 0; i < count; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = 8'($urandom);
      end
      acc    = 1'b0;
      waited = 0;
      while (!acc && waited < 50) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = frame_q[i];
        start    = (i == inject_idx);
        acc      = in_ready;
        @(posedge clk);
        waited++;
      end
      if (!acc) begin
        check_eq("byte_accept_wait", 64'(waited), 64'd0);
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Frame-level reference: decode length, expected words, checksum outcome
  task automatic run_frame(input string name);
    int                 n;
    int                 consumed;
    bit                 ok_exp;
    logic [1:0]         code;
    logic [7:0]         x;
    logic [ADDR_W+31:0] exp_w[$];
    n = int'({frame_q[1], frame_q[0]});
    exp_w.delete();
    if (n > MAXW) begin
      consumed = 2;
      ok_exp   = 1'b0;
      code     = 2'b01;
    end else begin
      x = 8'h00;
      for (int w = 0; w < n; w++)
        exp_w.push_back({ADDR_W'(w), frame_q[2+4*w+3], frame_q[2+4*w+2],
                         frame_q[2+4*w+1], frame_q[2+4*w]});
      for (int k = 2; k < 2 + 4 * n; k++) x ^= frame_q[k];
      consumed = 3 + 4 * n;
      ok_exp   = (frame_q[consumed-1] == x);
      code     = ok_exp ? 2'b00 : 2'b10;
    end
    begin_load();
    send_bytes(consumed);
    repeat (3) @(negedge clk);
    check_eq({name, "/load_done"}, 64'(load_done), 64'(ok_exp));
    check_eq({name, "/load_err"}, 64'(load_err), 64'(!ok_exp));
    check_eq({name, "/err_code"}, 64'(err_code), 64'(code));
    check_eq({name, "/cpu_rst_n"}, 64'(cpu_rst_n), 64'(ok_exp));
    check_eq({name, "/in_ready"}, 64'(in_ready), 64'd0);
    check_eq({name, "/words_loaded"}, 64'(words_loaded), 64'(exp_w.size()));
    check_eq({name, "/write_count"}, 64'(wr_q.size()), 64'(exp_w.size()));
    check_eq({name, "/cpu_rst_during_load"}, 64'(rst_viol), 64'd0);
    for (int k = 0; k < exp_w.size(); k++)
      if (k < wr_q.size()) check_eq({name, "/write"}, 64'(wr_q[k]), 64'(exp_w[k]));
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({in_ready, imem_we, imem_waddr, imem_wdata, cpu_rst_n, load_done, load_err,
                err_code, words_loaded});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", out_vec(), 64'd0);
    rst_neg_release();

    // Known program image; XOR of 13 05 00 00 93 05 15 00 is 0x95
    frame_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h15, 8'h00, 8'h95};
    run_frame("t1_good");
    if (wr_q.size() >= 2) begin
      check_eq("t1_word0", 64'(wr_q[0]), {28'd0, 4'd0, 32'h0000_0513});
      check_eq("t1_word1", 64'(wr_q[1]), {28'd0, 4'd1, 32'h0015_0593});
    end

    frame_q[10] = 8'h00;
    run_frame("t2_bad_csum");

    build_frame(17, 1'b1);
    run_frame("t3_overflow17");
    build_frame(16'h0100, 1'b1);
    run_frame("t3_overflow256");

    build_frame(0, 1'b1);
    run_frame("t4_empty");

    build_frame(MAXW, 1'b1);
    run_frame("full_image");

    for (int it = 0; it < 10; it++) begin
      if (it % 5 == 4) build_frame($urandom_range(MAXW + 1, 300), 1'b1);
      else             build_frame($urandom_range(0, MAXW), $urandom_range(0, 3) != 0);
      run_frame("random");
    end

    inject_idx = 7;
    build_frame(4, 1'b1);
    run_frame("start_mid_load");
    inject_idx = -1;

    // Stall mid-word until the idle timeout fires
    build_frame(2, 1'b1);
    begin_load();
    send_bytes(5);
    repeat (TIMEOUT - 2) @(negedge clk);
    check_eq("t5_no_early_timeout", 64'(load_err), 64'd0);
    repeat (4) @(negedge clk);
    check_eq("t5_timeout_err", 64'(load_err), 64'd1);
    check_eq("t5_timeout_code", 64'(err_code), 64'd3);
    check_eq("t5_timeout_cpu_rst", 64'(cpu_rst_n), 64'd0);
    build_frame(3, 1'b1);
    run_frame("t5_recover");

    // Asynchronous reset in the middle of the payload
    build_frame(3, 1'b1);
    begin_load();
    send_bytes(8);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("t6_async_reset", out_vec(), 64'd0);
    rst_neg_release();
    build_frame(3, 1'b1);
    run_frame("t6_recover");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  task automatic rst_neg_release();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

endmodule

`default_nettype wire
